// File: rtl/pred_debounce.sv
// Debounces the one-bit ADC threshold predicate over qualified samples.
// Produces a stable predicate, rise/fall pulses and a saturating glitch count.
module pred_debounce #(
    parameter int DEBOUNCE_CNT = 4,
    parameter int CNT_W        = 8,
    parameter int GLITCH_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic                pred_in,
    input  logic                clear_stats,
    output logic                pred_valid,
    output logic                pred_stable,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [2:0] {
        INIT,
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } state_t;

    localparam logic [CNT_W-1:0]    TARGET     = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0]    ONE        = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             candidate;

    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] init_cnt;
    logic             glitch_hit;

    assign count_inc = counter + ONE;

    // In INIT a disagreeing sample restarts the run at one.
    assign init_cnt = (pred_in == candidate) ? count_inc : ONE;

    assign glitch_hit = sample_valid &&
                        (((state == PEND_HI) && !pred_in) ||
                         ((state == PEND_LO) &&  pred_in));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            counter     <= '0;
            candidate   <= 1'b0;
            pred_valid  <= 1'b0;
            pred_stable <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            glitch_cnt  <= '0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            if (clear_stats) begin
                glitch_cnt <= '0;
            end else if (glitch_hit && (glitch_cnt != GLITCH_MAX)) begin
                glitch_cnt <= glitch_cnt + 1'b1;
            end

            if (sample_valid) begin
                unique case (state)
                    INIT: begin
                        candidate <= pred_in;
                        if (init_cnt == TARGET) begin
                            state       <= pred_in ? STABLE_HI : STABLE_LO;
                            pred_stable <= pred_in;
                            pred_valid  <= 1'b1;
                            counter     <= '0;
                        end else begin
                            counter <= init_cnt;
                        end
                    end
                    STABLE_LO: begin
                        if (pred_in) begin
                            if (ONE == TARGET) begin
                                state       <= STABLE_HI;
                                pred_stable <= 1'b1;
                                rise_pulse  <= 1'b1;
                                counter     <= '0;
                            end else begin
                                state   <= PEND_HI;
                                counter <= ONE;
                            end
                        end
                    end
                    PEND_HI: begin
                        if (pred_in) begin
                            if (count_inc == TARGET) begin
                                state       <= STABLE_HI;
                                pred_stable <= 1'b1;
                                rise_pulse  <= 1'b1;
                                counter     <= '0;
                            end else begin
                                counter <= count_inc;
                            end
                        end else begin
                            state   <= STABLE_LO;
                            counter <= '0;
                        end
                    end
                    STABLE_HI: begin
                        if (!pred_in) begin
                            if (ONE == TARGET) begin
                                state       <= STABLE_LO;
                                pred_stable <= 1'b0;
                                fall_pulse  <= 1'b1;
                                counter     <= '0;
                            end else begin
                                state   <= PEND_LO;
                                counter <= ONE;
                            end
                        end
                    end
                    PEND_LO: begin
                        if (!pred_in) begin
                            if (count_inc == TARGET) begin
                                state       <= STABLE_LO;
                                pred_stable <= 1'b0;
                                fall_pulse  <= 1'b1;
                                counter     <= '0;
                            end else begin
                                counter <= count_inc;
                            end
                        end else begin
                            state   <= STABLE_HI;
                            counter <= '0;
                        end
                    end
                    default: begin
                        state   <= INIT;
                        counter <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pred_debounce.sv
// Directed bench for pred_debounce: three instances cover
// DEBOUNCE_CNT=4, a 2-bit glitch counter and DEBOUNCE_CNT=1.
module tb_pred_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_valid = 1'b0;
    logic pred_in = 1'b0;
    logic clear_stats = 1'b0;

    logic        pv4, ps4, r4, f4;
    logic [15:0] g4;
    logic        pvg, psg, rg, fg;
    logic [1:0]  g2;
    logic        pv1, ps1, r1, f1;
    logic [15:0] g1;

    logic [3:0] st4;
    logic [3:0] st1;
    logic [3:0] exp_st;

    int n_tests = 0;
    int n_fail  = 0;

    assign st4 = {pv4, ps4, r4, f4};
    assign st1 = {pv1, ps1, r1, f1};

    always #5 clk = ~clk;

    pred_debounce #(.DEBOUNCE_CNT(4), .CNT_W(8), .GLITCH_W(16)) u_d4 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .pred_in(pred_in), .clear_stats(clear_stats),
        .pred_valid(pv4), .pred_stable(ps4), .rise_pulse(r4),
        .fall_pulse(f4), .glitch_cnt(g4)
    );

    pred_debounce #(.DEBOUNCE_CNT(4), .CNT_W(8), .GLITCH_W(2)) u_g2 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .pred_in(pred_in), .clear_stats(clear_stats),
        .pred_valid(pvg), .pred_stable(psg), .rise_pulse(rg),
        .fall_pulse(fg), .glitch_cnt(g2)
    );

    pred_debounce #(.DEBOUNCE_CNT(1), .CNT_W(8), .GLITCH_W(16)) u_d1 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .pred_in(pred_in), .clear_stats(clear_stats),
        .pred_valid(pv1), .pred_stable(ps1), .rise_pulse(r1),
        .fall_pulse(f1), .glitch_cnt(g1)
    );

    // Present one cycle of input, then sample outputs 1ns after the edge.
    task automatic step(input logic v, input logic p);
        sample_valid = v;
        pred_in      = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        pred_in      = 1'b0;
        clear_stats  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (st4 !== 4'b0000 || g4 !== 16'd0) begin
            $display("FAIL reset_state: st=%b g=%0d want 0000 0", st4, g4);
            n_fail++;
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        n_tests++;
        if (st4 !== 4'b0000) begin
            $display("FAIL reset_mid: st=%b want 0000", st4);
            n_fail++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            exp_st = (i == 3) ? 4'b1100 : 4'b0000;
            n_tests++;
            if (st4 !== exp_st) begin
                $display("FAIL reset_reaccept[%0d]: st=%b want %b",
                         i, st4, exp_st);
                n_fail++;
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (st4 !== 4'b0000) begin
            $display("FAIL reset_from_stable: st=%b want 0000", st4);
            n_fail++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_gapped();
        do_reset();
        for (int s = 0; s < 4; s++) begin
            exp_st = (s == 3) ? 4'b1000 : 4'b0000;
            step(1'b1, 1'b0);
            n_tests++;
            if (st4 !== exp_st) begin
                $display("FAIL gapped_strobe[%0d]: st=%b want %b",
                         s, st4, exp_st);
                n_fail++;
            end
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
            n_tests++;
            if (st4 !== exp_st) begin
                $display("FAIL gapped_idle[%0d]: st=%b want %b",
                         s, st4, exp_st);
                n_fail++;
            end
        end
    endtask

    // Continues from the stable-low state left by test_gapped.
    task automatic test_rise_fall();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            exp_st = (i == 3) ? 4'b1110 : 4'b1000;
            n_tests++;
            if (st4 !== exp_st) begin
                $display("FAIL rise[%0d]: st=%b want %b", i, st4, exp_st);
                n_fail++;
            end
        end
        step(1'b0, 1'b1);
        n_tests++;
        if (st4 !== 4'b1100) begin
            $display("FAIL rise_end: st=%b want 1100", st4);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            exp_st = (i == 3) ? 4'b1001 : 4'b1100;
            n_tests++;
            if (st4 !== exp_st) begin
                $display("FAIL fall[%0d]: st=%b want %b", i, st4, exp_st);
                n_fail++;
            end
        end
        step(1'b1, 1'b0);
        n_tests++;
        if (st4 !== 4'b1000 || g4 !== 16'd0) begin
            $display("FAIL fall_end: st=%b g=%0d want 1000 0", st4, g4);
            n_fail++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            n_tests++;
            if (st4 !== 4'b1100 || g4 !== 16'(k + 1)) begin
                $display("FAIL glitch[%0d]: st=%b g=%0d want 1100 %0d",
                         k, st4, g4, k + 1);
                n_fail++;
            end
            n_tests++;
            if (g2 !== ((k >= 2) ? 2'd3 : 2'(k + 1))) begin
                $display("FAIL glitch_sat[%0d]: g2=%0d want %0d",
                         k, g2, (k >= 2) ? 3 : k + 1);
                n_fail++;
            end
        end
    endtask

    // Continues from test_glitch: g4=5, g2 saturated at 3.
    task automatic test_clear_sat();
        clear_stats = 1'b1;
        step(1'b0, 1'b1);
        clear_stats = 1'b0;
        n_tests++;
        if (g4 !== 16'd0 || g2 !== 2'd0) begin
            $display("FAIL clear: g4=%0d g2=%0d want 0 0", g4, g2);
            n_fail++;
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
        end
        n_tests++;
        if (g4 !== 16'd4 || g2 !== 2'd3) begin
            $display("FAIL recount: g4=%0d g2=%0d want 4 3", g4, g2);
            n_fail++;
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        clear_stats = 1'b1;
        step(1'b1, 1'b1);
        clear_stats = 1'b0;
        n_tests++;
        if (g4 !== 16'd0 || g2 !== 2'd0 || st4 !== 4'b1100) begin
            $display("FAIL clear_vs_glitch: g4=%0d g2=%0d st=%b want 0 0 1100",
                     g4, g2, st4);
            n_fail++;
        end
    endtask

    task automatic test_pass_through();
        logic p;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            p = (i % 2 == 0);
            step(1'b1, p);
            exp_st = {1'b1, p, (i > 0) && p, (i > 0) && !p};
            n_tests++;
            if (st1 !== exp_st || g1 !== 16'd0) begin
                $display("FAIL pass[%0d]: st=%b g=%0d want %b 0",
                         i, st1, g1, exp_st);
                n_fail++;
            end
            n_tests++;
            if (pv4 !== 1'b0) begin
                $display("FAIL alt_no_accept[%0d]: pv4=%b want 0", i, pv4);
                n_fail++;
            end
        end
        step(1'b0, 1'b1);
        n_tests++;
        if (st1 !== 4'b1000) begin
            $display("FAIL pass_idle: st=%b want 1000", st1);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_gapped();
        test_rise_fall();
        test_glitch();
        test_clear_sat();
        test_pass_through();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pred_debounce.md
Name: pred_debounce

Overview:
- Sits directly downstream of the ADC threshold predicate stage and consumes its one-bit predicate, qualified by the ADC data-ready strobe.
- Declares a new predicate value only after DEBOUNCE_CNT consecutive qualified samples agree, so ADC noise near the threshold does not toggle the monitor input.
- Outputs a registered stable predicate, single-cycle rise/fall event pulses and a saturating glitch counter. Downstream temporal monitors and software status read these.

Parameters:
- DEBOUNCE_CNT, 4: number of consecutive agreeing qualified samples needed to accept a value. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 8: width of the internal agreement counter.
- GLITCH_W, 16: width of the glitch counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_valid  input  1  ADC data-ready strobe; pred_in is sampled only when this is 1.
- pred_in  input  1  predicate from the threshold stage (1 = sample >= threshold).
- clear_stats  input  1  synchronous clear of glitch_cnt.
- pred_valid  output  1  1 once the first value has been accepted after reset.
- pred_stable  output  1  debounced predicate.
- rise_pulse  output  1  one-cycle pulse when pred_stable goes 0->1.
- fall_pulse  output  1  one-cycle pulse when pred_stable goes 1->0.
- glitch_cnt  output  GLITCH_W  count of aborted pending transitions; saturates at all-ones.

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - state=INIT, counter=0, candidate=0.
  - pred_valid=0, pred_stable=0, rise_pulse=0, fall_pulse=0, glitch_cnt=0.
  - Reset asserted mid-operation discards all pending state immediately.
- Cycles with sample_valid=0 change no state or counter. Pulses are still forced to 0 on that cycle.
- States: INIT, STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
- INIT (one qualified sample per step):
  - Sample equal to candidate: counter+1.
  - Sample different: candidate=sample, counter=1.
  - When the counter value reaches DEBOUNCE_CNT, go to STABLE_HI or STABLE_LO.
  - At that transition, set pred_stable=candidate and pred_valid=1. No rise/fall pulse is generated on this first acceptance.
- STABLE_x:
  - Sample equal to the current value: stay.
  - Sample differing: counter=1.
    - If DEBOUNCE_CNT=1, flip immediately.
    - Otherwise go to PEND_x.
- PEND_x:
  - Differing sample: counter+1. On reaching DEBOUNCE_CNT, flip pred_stable, enter the opposite STABLE state and pulse rise or fall.
  - Sample equal to the stable value: return to STABLE_x, counter=0, glitch_cnt+1 (saturating).
- Latency:
  - Outputs are registered.
  - pred_stable and the pulse update on the clock edge that samples the DEBOUNCE_CNT-th agreeing qualified sample. They are visible in the cycle after that sample is presented.
  - With DEBOUNCE_CNT=1 this is a one-cycle registered pass-through, with no glitches possible.
- Pulses are high for exactly one clk cycle. Rise and fall are never high together.
- glitch_cnt:
  - Holds at 2^GLITCH_W-1 once reached.
  - clear_stats=1 sets it to 0.
  - If clear_stats and a glitch occur in the same cycle, clear wins and the result is 0.
- Counter never exceeds DEBOUNCE_CNT and cannot wrap.

Test Plan:
- Reset mid-operation: DEBOUNCE_CNT=4, pred_in=1 with sample_valid on every cycle, assert rst after 2 samples -> all outputs 0 immediately. After release, 4 samples are needed before pred_valid=1 and pred_stable=1, with no rise_pulse.
- Gapped strobes and first acceptance: sample_valid every 3rd cycle, pred_in=0 for 4 strobes -> pred_valid rises after the 4th strobe and pred_stable=0. Idle cycles must not advance the counter.
- Rise and fall debounce: stable 0, then 4 qualified 1s -> pred_stable=1 and rise_pulse high exactly 1 cycle. Then 4 qualified 0s -> fall_pulse for 1 cycle.
- Glitch counting: stable 1, then qualified sequence 0,0,1 -> pred_stable stays 1, glitch_cnt=1. Repeat 5 times -> glitch_cnt=5.
- Clear and saturation: GLITCH_W=2, inject 5 glitches -> glitch_cnt saturates at 3. Assert clear_stats in the same cycle as a glitch -> glitch_cnt=0.
- Pass-through: DEBOUNCE_CNT=1, alternating pred_in on every strobe -> pred_stable follows with 1-cycle latency, alternating rise/fall pulses, glitch_cnt stays 0.
